// File: rtl/axi_grid_wr_depacketizer.sv
// Grid write-path receive end: rebuilds AXI AW/W bursts from header + data flits
// and returns each AXI B response to the grid as a single response flit.
module axi_grid_wr_depacketizer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int FLIT_WIDTH = DATA_WIDTH + DATA_WIDTH/8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [FLIT_WIDTH-1:0]   flit_data_i,
  input  logic                    flit_last_i,
  input  logic                    flit_valid_i,
  output logic                    flit_ready_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  input  logic [ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]              b_resp_i,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  output logic [ID_WIDTH+1:0]     bflit_data_o,
  output logic                    bflit_valid_o,
  input  logic                    bflit_ready_i,
  output logic                    err_o
);

  localparam int LEN_LSB   = ADDR_WIDTH;
  localparam int SIZE_LSB  = ADDR_WIDTH + 8;
  localparam int BURST_LSB = ADDR_WIDTH + 11;
  localparam int ID_LSB    = ADDR_WIDTH + 13;

  if (ID_LSB + ID_WIDTH > FLIT_WIDTH) begin : g_hdr_fit_check
    $fatal(1, "header fields do not fit in FLIT_WIDTH");
  end
  if ((DATA_WIDTH % 8 != 0) || (FLIT_WIDTH != DATA_WIDTH + DATA_WIDTH/8)) begin : g_width_check
    $fatal(1, "DATA_WIDTH must be a multiple of 8 and FLIT_WIDTH must not be overridden");
  end

  typedef enum logic [1:0] {ST_HDR, ST_AW, ST_DATA} state_t;

  state_t     state_q, state_d;
  logic [7:0] beat_cnt_q;
  logic       w_hs;

  // Data beats pass straight through; only the framing decision is stateful.
  assign w_data_o = flit_data_i[DATA_WIDTH-1:0];
  assign w_strb_o = flit_data_i[FLIT_WIDTH-1:DATA_WIDTH];
  assign w_hs     = w_valid_o && w_ready_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    flit_ready_o = 1'b0;
    aw_valid_o   = 1'b0;
    w_valid_o    = 1'b0;
    w_last_o     = 1'b0;
    case (state_q)
      ST_HDR: begin
        flit_ready_o = 1'b1;
        if (flit_valid_i && !flit_last_i) state_d = ST_AW;
      end
      ST_AW: begin
        aw_valid_o = 1'b1;
        if (aw_ready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        w_valid_o    = flit_valid_i;
        flit_ready_o = w_ready_i;
        w_last_o     = (beat_cnt_q == aw_len_o);
        if (flit_valid_i && w_ready_i && w_last_o) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= ST_HDR;
      beat_cnt_q <= '0;
      aw_id_o    <= '0;
      aw_addr_o  <= '0;
      aw_len_o   <= '0;
      aw_size_o  <= '0;
      aw_burst_o <= '0;
      err_o      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      if (state_q == ST_HDR && flit_valid_i) begin
        if (flit_last_i) begin
          err_o <= 1'b1;  // single-flit packet has no data: drop it
        end else begin
          aw_addr_o  <= flit_data_i[ADDR_WIDTH-1:0];
          aw_len_o   <= flit_data_i[LEN_LSB +: 8];
          aw_size_o  <= flit_data_i[SIZE_LSB +: 3];
          aw_burst_o <= flit_data_i[BURST_LSB +: 2];
          aw_id_o    <= flit_data_i[ID_LSB +: ID_WIDTH];
          beat_cnt_q <= '0;
        end
      end
      if (state_q == ST_DATA && w_hs) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        // The beat count frames the burst; a disagreeing last flag is only reported.
        if (flit_last_i != w_last_o) err_o <= 1'b1;
      end
    end
  end

  assign b_ready_o = !bflit_valid_o || bflit_ready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bflit_valid_o <= 1'b0;
      bflit_data_o  <= '0;
    end else if (b_valid_i && b_ready_o) begin
      bflit_valid_o <= 1'b1;
      bflit_data_o  <= {b_resp_i, b_id_i};
    end else if (bflit_ready_i) begin
      bflit_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_grid_wr_depacketizer.sv
// Self-checking bench for axi_grid_wr_depacketizer: directed scenarios plus a
// randomized run scored against a packet-level reference model.
module tb_axi_grid_wr_depacketizer;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int SW  = DW / 8;
  localparam int FW  = DW + SW;
  localparam int AWB = IW + AW + 13;
  localparam int WB  = 1 + SW + DW;
  localparam int OW  = 5 + (IW + 2) + AWB + 1;
  localparam logic [OW-1:0] RST_OUTS = {5'b00110, {(OW-5){1'b0}}};

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [FW-1:0] flit_data = '0;
  logic          flit_last = 1'b0;
  logic          flit_valid = 1'b0;
  logic          flit_ready;
  logic [IW-1:0] aw_id;
  logic [AW-1:0] aw_addr;
  logic [7:0]    aw_len;
  logic [2:0]    aw_size;
  logic [1:0]    aw_burst;
  logic          aw_valid;
  logic          aw_ready = 1'b1;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic          w_last;
  logic          w_valid;
  logic          w_ready = 1'b1;
  logic [IW-1:0] b_id = '0;
  logic [1:0]    b_resp = '0;
  logic          b_valid = 1'b0;
  logic          b_ready;
  logic [IW+1:0] bflit_data;
  logic          bflit_valid;
  logic          bflit_ready = 1'b1;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [AWB-1:0]  aw_obs[$];
  logic [WB-1:0]   w_obs[$];
  logic [IW+1:0]   bf_obs[$];

  always #5 clk = ~clk;

  axi_grid_wr_depacketizer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk_i(clk), .arst_i(arst),
    .flit_data_i(flit_data), .flit_last_i(flit_last), .flit_valid_i(flit_valid), .flit_ready_o(flit_ready),
    .aw_id_o(aw_id), .aw_addr_o(aw_addr), .aw_len_o(aw_len), .aw_size_o(aw_size), .aw_burst_o(aw_burst),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready),
    .w_data_o(w_data), .w_strb_o(w_strb), .w_last_o(w_last), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .b_id_i(b_id), .b_resp_i(b_resp), .b_valid_i(b_valid), .b_ready_o(b_ready),
    .bflit_data_o(bflit_data), .bflit_valid_o(bflit_valid), .bflit_ready_i(bflit_ready),
    .err_o(err)
  );

  // Handshake monitor, sampled on the falling edge where everything is settled.
  always @(negedge clk) begin
    if (!arst) begin
      if (aw_valid && aw_ready) aw_obs.push_back({aw_id, aw_addr, aw_len, aw_size, aw_burst});
      if (w_valid && w_ready)   w_obs.push_back({w_last, w_strb, w_data});
      if (bflit_valid && bflit_ready) bf_obs.push_back(bflit_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [FW-1:0] mk_hdr(input logic [AW-1:0] a, input logic [7:0] l,
                                           input logic [2:0] s, input logic [1:0] b,
                                           input logic [IW-1:0] id, input logic [FW-1:0] junk);
    logic [FW-1:0] f;
    f = junk;
    f[AW-1:0]    = a;
    f[AW +: 8]   = l;
    f[AW+8 +: 3] = s;
    f[AW+11 +: 2] = b;
    f[AW+13 +: IW] = id;
    return f;
  endfunction

  function automatic logic [OW-1:0] outs();
    return {aw_valid, w_valid, flit_ready, b_ready, bflit_valid, bflit_data,
            aw_id, aw_addr, aw_len, aw_size, aw_burst, err};
  endfunction

  task automatic reset_dut();
    arst = 1'b1;
    flit_valid = 1'b0; flit_last = 1'b0; flit_data = '0; b_valid = 1'b0;
    aw_ready = 1'b1; w_ready = 1'b1; bflit_ready = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    aw_obs.delete(); w_obs.delete(); bf_obs.delete();
  endtask

  task automatic send_flit(input logic [FW-1:0] d, input logic l);
    int n = 0;
    flit_data = d; flit_last = l; flit_valid = 1'b1;
    @(negedge clk);
    while (!flit_ready && n < 2000) begin n++; @(negedge clk); end
    total++;
    if (flit_ready !== 1'b1) begin
      bad++; $display("FAIL flit_timeout: flit_ready=%b required=1", flit_ready);
    end
    @(posedge clk); #1;
    flit_valid = 1'b0;
  endtask

  task automatic send_b(input logic [IW-1:0] id, input logic [1:0] r);
    int n = 0;
    b_id = id; b_resp = r; b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && n < 2000) begin n++; @(negedge clk); end
    total++;
    if (b_ready !== 1'b1) begin
      bad++; $display("FAIL b_timeout: b_ready=%b required=1", b_ready);
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (outs() !== RST_OUTS) begin
      bad++; $display("FAIL reset_values: got=%h required=%h", outs(), RST_OUTS);
    end
    arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_burst();
    logic [DW-1:0] d[4];
    logic [SW-1:0] s[4];
    reset_dut();
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; s[i] = SW'($urandom); end
    flit_valid = 1'b1; flit_last = 1'b0;
    flit_data = mk_hdr(32'h1000, 8'd3, 3'd3, 2'd1, 4'd5, '0);
    @(negedge clk);
    total++;
    if (flit_ready !== 1'b1) begin bad++; $display("FAIL basic_hdr_ready: got=%b required=1", flit_ready); end
    @(posedge clk); #1;
    flit_data = {s[0], d[0]};
    @(negedge clk);
    total++;
    if ({aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst} !== {1'b1, 4'd5, 32'h1000, 8'd3, 3'd3, 2'd1}) begin
      bad++; $display("FAIL basic_aw: got=%h required=%h",
                      {aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst}, {1'b1, 4'd5, 32'h1000, 8'd3, 3'd3, 2'd1});
    end
    total++;
    if ({flit_ready, w_valid} !== 2'b00) begin
      bad++; $display("FAIL basic_aw_stall: ready,w_valid got=%b required=00", {flit_ready, w_valid});
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      flit_data = {s[i], d[i]}; flit_last = (i == 3);
      @(negedge clk);
      total++;
      if ({w_valid, w_last, w_strb, w_data} !== {1'b1, i == 3, s[i], d[i]}) begin
        bad++; $display("FAIL basic_w_beat%0d: got=%h required=%h", i,
                        {w_valid, w_last, w_strb, w_data}, {1'b1, i == 3, s[i], d[i]});
      end
      @(posedge clk); #1;
    end
    flit_valid = 1'b0; flit_last = 1'b0;
    @(negedge clk);
    total++;
    if ({err, aw_valid, w_valid, flit_ready} !== 4'b0001) begin
      bad++; $display("FAIL basic_end: err,aw_v,w_v,ready got=%b required=0001", {err, aw_valid, w_valid, flit_ready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len0();
    logic [AW-1:0] a1, a2;
    logic [DW-1:0] d1, d2;
    reset_dut();
    a1 = $urandom; a2 = $urandom; d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    flit_valid = 1'b1; flit_last = 1'b0;
    flit_data = mk_hdr(a1, 8'd0, 3'd2, 2'd1, 4'd9, FW'({$urandom, $urandom, $urandom}));
    @(posedge clk); #1;
    flit_data = {8'hff, d1}; flit_last = 1'b1;
    @(negedge clk);
    total++;
    if ({aw_valid, aw_addr, aw_len} !== {1'b1, a1, 8'd0}) begin
      bad++; $display("FAIL len0_aw: got=%h required=%h", {aw_valid, aw_addr, aw_len}, {1'b1, a1, 8'd0});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({w_valid, w_last, w_data} !== {2'b11, d1}) begin
      bad++; $display("FAIL len0_beat: got=%h required=%h", {w_valid, w_last, w_data}, {2'b11, d1});
    end
    @(posedge clk); #1;
    flit_data = mk_hdr(a2, 8'd0, 3'd3, 2'd0, 4'd1, '0); flit_last = 1'b0;
    @(negedge clk);
    total++;
    if ({flit_ready, aw_valid, w_valid} !== 3'b100) begin
      bad++; $display("FAIL len0_back_in_hdr: ready,aw_v,w_v got=%b required=100", {flit_ready, aw_valid, w_valid});
    end
    @(posedge clk); #1;
    flit_data = {8'h0f, d2}; flit_last = 1'b1;
    @(negedge clk);
    total++;
    if ({aw_valid, aw_addr} !== {1'b1, a2}) begin
      bad++; $display("FAIL len0_next_aw: got=%h required=%h", {aw_valid, aw_addr}, {1'b1, a2});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({w_valid, w_last, w_data} !== {2'b11, d2}) begin
      bad++; $display("FAIL len0_next_beat: got=%h required=%h", {w_valid, w_last, w_data}, {2'b11, d2});
    end
    @(posedge clk); #1;
    flit_valid = 1'b0; flit_last = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d[4];
    logic [SW-1:0] s[4];
    logic [AWB-1:0] exp_aw;
    logic [AW-1:0] a;
    int idx, guard;
    logic ph;
    reset_dut();
    foreach (d[i]) begin d[i] = {$urandom, $urandom}; s[i] = SW'($urandom); end
    a = $urandom;
    exp_aw = {4'd7, a, 8'd3, 3'd3, 2'd2};
    aw_ready = 1'b0;
    flit_valid = 1'b1; flit_last = 1'b0;
    flit_data = mk_hdr(a, 8'd3, 3'd3, 2'd2, 4'd7, '0);
    @(posedge clk); #1;
    flit_data = {s[0], d[0]};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({aw_valid, flit_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst} !== {2'b10, exp_aw}) begin
        bad++; $display("FAIL bp_aw_stall%0d: got=%h required=%h", k,
                        {aw_valid, flit_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst}, {2'b10, exp_aw});
      end
      @(posedge clk); #1;
    end
    aw_ready = 1'b1; w_ready = 1'b0;
    @(posedge clk); #1;
    idx = 0; guard = 0; ph = 1'b0;
    while (idx < 4 && guard < 40) begin
      flit_data = {s[idx], d[idx]}; flit_last = (idx == 3); w_ready = ph;
      @(negedge clk);
      total++;
      if ({flit_ready, w_valid, w_last, w_data} !== {ph, 1'b1, idx == 3, d[idx]}) begin
        bad++; $display("FAIL bp_w_track: got=%h required=%h",
                        {flit_ready, w_valid, w_last, w_data}, {ph, 1'b1, idx == 3, d[idx]});
      end
      @(posedge clk); #1;
      if (ph) idx++;
      ph = !ph; guard++;
    end
    flit_valid = 1'b0; flit_last = 1'b0; w_ready = 1'b1;
    @(negedge clk);
    total++;
    if (w_obs.size() != 4 || aw_obs.size() != 1) begin
      bad++; $display("FAIL bp_counts: w=%0d aw=%0d required w=4 aw=1", w_obs.size(), aw_obs.size());
    end
    for (int i = 0; i < 4 && i < w_obs.size(); i++) begin
      total++;
      if (w_obs[i] !== {i == 3, s[i], d[i]}) begin
        bad++; $display("FAIL bp_w_data%0d: got=%h required=%h", i, w_obs[i], {i == 3, s[i], d[i]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_framing_err();
    reset_dut();
    flit_valid = 1'b1; flit_last = 1'b1;
    flit_data = mk_hdr(32'h2000, 8'd1, 3'd3, 2'd1, 4'd3, '0);
    @(negedge clk);
    total++;
    if (flit_ready !== 1'b1) begin bad++; $display("FAIL err_hdr_consumed: ready=%b required=1", flit_ready); end
    @(posedge clk); #1;
    flit_valid = 1'b0; flit_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({err, aw_valid, flit_ready} !== 3'b101) begin
        bad++; $display("FAIL err_hdr_sticky%0d: err,aw_v,ready got=%b required=101", k, {err, aw_valid, flit_ready});
      end
      @(posedge clk); #1;
    end
    total++;
    if (aw_obs.size() != 0) begin bad++; $display("FAIL err_hdr_no_aw: aw count=%0d required=0", aw_obs.size()); end

    reset_dut();
    send_flit(mk_hdr(32'h3000, 8'd2, 3'd3, 2'd1, 4'd4, '0), 1'b0);
    send_flit({8'h01, 64'h1111}, 1'b0);
    send_flit({8'h02, 64'h2222}, 1'b1);
    send_flit({8'h03, 64'h3333}, 1'b0);
    @(negedge clk);
    total++;
    if ({err, flit_ready} !== 2'b11) begin
      bad++; $display("FAIL err_last_mismatch: err,ready got=%b required=11", {err, flit_ready});
    end
    total++;
    if (w_obs.size() != 3) begin
      bad++; $display("FAIL err_beats: count=%0d required=3", w_obs.size());
    end else begin
      total++;
      if ({w_obs[0], w_obs[1], w_obs[2]} !== {1'b0, 8'h01, 64'h1111, 1'b0, 8'h02, 64'h2222, 1'b1, 8'h03, 64'h3333}) begin
        bad++; $display("FAIL err_beat_data: got=%h %h %h", w_obs[0], w_obs[1], w_obs[2]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bresp();
    logic [IW+1:0] prev, cur;
    reset_dut();
    bflit_ready = 1'b0;
    b_valid = 1'b1; b_id = 4'd2; b_resp = 2'd0;
    @(negedge clk);
    total++;
    if ({b_ready, bflit_valid} !== 2'b10) begin
      bad++; $display("FAIL b_first_accept: b_ready,bflit_v got=%b required=10", {b_ready, bflit_valid});
    end
    @(posedge clk); #1;
    b_id = 4'd3; b_resp = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({bflit_valid, bflit_data, b_ready} !== {1'b1, 2'd0, 4'd2, 1'b0}) begin
        bad++; $display("FAIL b_hold%0d: got=%h required=%h", k, {bflit_valid, bflit_data, b_ready}, {1'b1, 2'd0, 4'd2, 1'b0});
      end
      @(posedge clk); #1;
    end
    bflit_ready = 1'b1;
    @(negedge clk);
    total++;
    if (b_ready !== 1'b1) begin bad++; $display("FAIL b_drain_fill: b_ready=%b required=1", b_ready); end
    @(posedge clk); #1;
    prev = {2'd2, 4'd3};
    for (int k = 0; k < 6; k++) begin
      cur = {2'($urandom), 4'(k + 6)};
      b_resp = cur[IW+1:IW]; b_id = cur[IW-1:0];
      @(negedge clk);
      total++;
      if ({bflit_valid, bflit_data, b_ready} !== {1'b1, prev, 1'b1}) begin
        bad++; $display("FAIL b_stream%0d: got=%h required=%h", k, {bflit_valid, bflit_data, b_ready}, {1'b1, prev, 1'b1});
      end
      @(posedge clk); #1;
      prev = cur;
    end
    b_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bflit_valid, bflit_data} !== {1'b1, prev}) begin
      bad++; $display("FAIL b_last: got=%h required=%h", {bflit_valid, bflit_data}, {1'b1, prev});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (bflit_valid !== 1'b0) begin bad++; $display("FAIL b_empty: bflit_valid=%b required=0", bflit_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    logic [DW-1:0] d0, d1;
    reset_dut();
    bflit_ready = 1'b0;
    send_b(4'd1, 2'd3);
    send_flit(mk_hdr(32'h4000, 8'd7, 3'd3, 2'd1, 4'd6, '0), 1'b0);
    send_flit({8'hff, 64'hA0}, 1'b0);
    send_flit({8'hff, 64'hA1}, 1'b0);
    flit_data = {8'hff, 64'hA2}; flit_last = 1'b0; flit_valid = 1'b1;
    #2 arst = 1'b1;
    #1;
    total++;
    if (outs() !== RST_OUTS) begin
      bad++; $display("FAIL midreset_values: got=%h required=%h", outs(), RST_OUTS);
    end
    flit_valid = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk); #1;
    aw_obs.delete(); w_obs.delete(); bf_obs.delete();
    bflit_ready = 1'b1;
    d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
    send_flit(mk_hdr(32'h5000, 8'd1, 3'd3, 2'd1, 4'd2, '0), 1'b0);
    send_flit({8'h55, d0}, 1'b0);
    send_flit({8'haa, d1}, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (aw_obs.size() != 1 || w_obs.size() != 2 || bf_obs.size() != 0 || err !== 1'b0) begin
      bad++; $display("FAIL midreset_restart: aw=%0d w=%0d bf=%0d err=%b required 1 2 0 0",
                      aw_obs.size(), w_obs.size(), bf_obs.size(), err);
    end else begin
      total++;
      if ({aw_obs[0], w_obs[0], w_obs[1]} !== {4'd2, 32'h5000, 8'd1, 3'd3, 2'd1, 1'b0, 8'h55, d0, 1'b1, 8'haa, d1}) begin
        bad++; $display("FAIL midreset_content: aw=%h w0=%h w1=%h", aw_obs[0], w_obs[0], w_obs[1]);
      end
    end
    @(posedge clk); #1;
  endtask

  // Randomized traffic: expected AW/W/B streams are derived from the packet list alone.
  task automatic test_random();
    logic [FW:0]     flits[$];
    logic [AWB-1:0]  aw_exp[$];
    logic [WB-1:0]   w_exp[$];
    logic [IW+1:0]   bf_exp[$];
    logic [7:0]      len;
    logic [AW-1:0]   a;
    logic [IW-1:0]   id;
    logic [2:0]      sz;
    logic [1:0]      bu;
    logic [DW-1:0]   d;
    logic [SW-1:0]   s;
    logic            done_a, done_b;
    reset_dut();
    for (int p = 0; p < 24; p++) begin
      len = (p == 10) ? 8'd255 : 8'($urandom_range(0, 6));
      a = $urandom; id = IW'($urandom); sz = 3'($urandom); bu = 2'($urandom);
      flits.push_back({1'b0, mk_hdr(a, len, sz, bu, id, FW'({$urandom, $urandom, $urandom}))});
      aw_exp.push_back({id, a, len, sz, bu});
      for (int i = 0; i <= int'(len); i++) begin
        d = {$urandom, $urandom}; s = SW'($urandom);
        flits.push_back({i == int'(len), s, d});
        w_exp.push_back({i == int'(len), s, d});
      end
    end
    for (int k = 0; k < 30; k++) bf_exp.push_back((IW+2)'($urandom));
    done_a = 1'b0; done_b = 1'b0;
    fork
      begin
        foreach (flits[k]) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_flit(flits[k][FW-1:0], flits[k][FW]);
        end
        done_a = 1'b1;
      end
      begin
        foreach (bf_exp[k]) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send_b(bf_exp[k][IW-1:0], bf_exp[k][IW+1:IW]);
        end
        done_b = 1'b1;
      end
      begin
        while (!(done_a && done_b)) begin
          @(posedge clk); #1;
          aw_ready = 1'($urandom_range(0, 1));
          w_ready = 1'($urandom_range(0, 1));
          bflit_ready = 1'($urandom_range(0, 1));
        end
        aw_ready = 1'b1; w_ready = 1'b1; bflit_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (aw_obs.size() != aw_exp.size() || w_obs.size() != w_exp.size() || bf_obs.size() != bf_exp.size()) begin
      bad++; $display("FAIL rand_counts: aw=%0d/%0d w=%0d/%0d bf=%0d/%0d (got/required)",
                      aw_obs.size(), aw_exp.size(), w_obs.size(), w_exp.size(), bf_obs.size(), bf_exp.size());
    end
    foreach (aw_exp[k]) if (k < aw_obs.size()) begin
      total++;
      if (aw_obs[k] !== aw_exp[k]) begin bad++; $display("FAIL rand_aw%0d: got=%h required=%h", k, aw_obs[k], aw_exp[k]); end
    end
    foreach (w_exp[k]) if (k < w_obs.size()) begin
      total++;
      if (w_obs[k] !== w_exp[k]) begin bad++; $display("FAIL rand_w%0d: got=%h required=%h", k, w_obs[k], w_exp[k]); end
    end
    foreach (bf_exp[k]) if (k < bf_obs.size()) begin
      total++;
      if (bf_obs[k] !== bf_exp[k]) begin bad++; $display("FAIL rand_b%0d: got=%h required=%h", k, bf_obs[k], bf_exp[k]); end
    end
    total++;
    if ({err, flit_ready, bflit_valid} !== 3'b010) begin
      bad++; $display("FAIL rand_idle: err,ready,bflit_v got=%b required=010", {err, flit_ready, bflit_valid});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_len0();
    test_backpressure();
    test_framing_err();
    test_bresp();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_grid_wr_depacketizer.md
Name: axi_grid_wr_depacketizer

Overview:
Grid-side receive end of the write path. Accepts the flit stream that a grid slave NI produces (one header flit followed by data flits) and rebuilds a standard AXI AW + W write toward the attached subordinate. Also returns each AXI B response into the grid as a single response flit. It sits between a grid router egress port and a master NI's AXI request/response ports.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 64, AXI data width; must be a multiple of 8
ID_WIDTH, 4, AXI ID width
FLIT_WIDTH, DATA_WIDTH+DATA_WIDTH/8, flit payload width (derived; do not override)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
flit_data_i  in  FLIT_WIDTH  incoming flit payload
flit_last_i  in  1  marks final flit of packet
flit_valid_i  in  1  flit valid
flit_ready_o  out  1  flit ready
aw_id_o  out  ID_WIDTH  AXI AW id
aw_addr_o  out  ADDR_WIDTH  AXI AW address
aw_len_o  out  8  AXI AW len
aw_size_o  out  3  AXI AW size
aw_burst_o  out  2  AXI AW burst
aw_valid_o  out  1  AW valid
aw_ready_i  in  1  AW ready
w_data_o  out  DATA_WIDTH  AXI W data
w_strb_o  out  DATA_WIDTH/8  AXI W strobe
w_last_o  out  1  AXI W last
w_valid_o  out  1  W valid
w_ready_i  in  1  W ready
b_id_i  in  ID_WIDTH  AXI B id
b_resp_i  in  2  AXI B resp
b_valid_i  in  1  B valid
b_ready_o  out  1  B ready
bflit_data_o  out  ID_WIDTH+2  response flit {resp, id}
bflit_valid_o  out  1  response flit valid
bflit_ready_i  in  1  response flit ready
err_o  out  1  sticky framing-error flag

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-high (arst_i). All state is cleared immediately on assertion.
- Header flit field layout:
  - addr = flit[ADDR_WIDTH-1:0]
  - len = next 8 bits
  - size = next 3 bits
  - burst = next 2 bits
  - id = next ID_WIDTH bits
  - Remaining bits are ignored.
  - Elaboration check: ADDR_WIDTH+13+ID_WIDTH <= FLIT_WIDTH, else $fatal.
- Data flit layout: data = flit[DATA_WIDTH-1:0], strb = flit[FLIT_WIDTH-1:DATA_WIDTH].
- FSM states HDR, AW, DATA. Reset state is HDR.
- HDR:
  - flit_ready_o=1.
  - On handshake with flit_last_i=0: register the header fields, clear beat_cnt, go to AW.
  - On handshake with flit_last_i=1: this is a malformed packet. Drop the flit, set err_o, stay in HDR.
- AW:
  - aw_valid_o=1 with the registered fields; flit_ready_o=0.
  - On aw_ready_i, go to DATA.
  - Latency: header accepted in cycle N gives aw_valid_o high in cycle N+1. AW fields stay stable until the handshake.
- DATA (combinational pass-through, zero latency):
  - w_valid_o=flit_valid_i, flit_ready_o=w_ready_i.
  - w_last_o=(beat_cnt==aw_len).
  - beat_cnt increments on each W handshake.
  - On the handshake with w_last_o=1, go to HDR.
  - The beat count is authoritative. If flit_last_i differs from w_last_o on a handshake beat, set err_o; the beat is still forwarded unchanged.
- Outside DATA: w_valid_o=0. Outside AW: aw_valid_o=0.
- len=0 means a single beat; len=255 means 256 beats. beat_cnt is 8 bits and never wraps within a burst.
- B return:
  - One-entry registered buffer. b_ready_o = !bflit_valid_o || bflit_ready_i.
  - On a B handshake, load {resp,id} and set bflit_valid_o the next cycle.
  - Simultaneous drain and fill sustains 1 response per cycle.
  - The B path is independent of the FSM.
- Reset values: aw_valid_o=0, w_valid_o=0, flit_ready_o=1 (state HDR), b_ready_o=1, bflit_valid_o=0, bflit_data_o=0, aw_* fields=0, err_o=0.
- Reset mid-burst abandons the burst; no completion is generated. err_o clears only on reset.

Test Plan:
1. Header (addr=0x1000, len=3, size=3, burst=1, id=5) followed by 4 data flits with last on the 4th, all readies high -> AW in cycle N+1 with exact fields; 4 W beats with w_last only on beat 4; err_o=0.
2. len=0 packet, header then 1 data flit (last=1) -> one W beat with w_last=1; FSM returns to HDR; the next header is accepted the following cycle.
3. aw_ready_i held low 5 cycles, then w_ready_i toggled every other cycle -> flit_ready_o=0 throughout AW; AW fields stable; W beats track w_ready_i exactly; no data loss.
4. Header with flit_last=1 -> flit consumed, no AW issued, err_o=1 and stays 1. Separately, a data flit with last=1 at beat 1 of len=2 -> err_o=1 and 3 W beats still issued.
5. B with id=2, resp=OKAY while bflit_ready_i=0 -> bflit_valid_o=1 with data {0,2}; b_ready_o=0. A second B waits until bflit_ready_i=1, then back-to-back B responses flow at 1 per cycle.
6. Assert arst_i during beat 2 of a len=7 burst -> all outputs return to reset values immediately; the next header starts cleanly.
